rx_uart: RTL and testbench
==========================

Name: rx_uart

Overview:
- UART receiver; the receive-side counterpart of the team's TxUART transmitter.
- Deserialises start + 8 data bits (LSB first) + optional parity + 1 stop bit from an asynchronous line, using 16x oversampling.
- Baud select and parity mode use the same encoding as the transmitter control lines, so a Tx/Rx pair configured identically interoperates.
- Presents received bytes through a level-ready/ack handshake, with parity, framing and overrun flags.

Parameters:
- CLK_HZ, 18_432_000, system clock frequency in Hz; used to compute the oversample divisor.
- OVS, 16, oversample ticks per bit. Fixed at 16; mid-bit sample taken at tick 7 (0-based).

Ports:
- Clock  input  1  system clock; all logic on the rising edge.
- Rst  input  1  synchronous, active-low reset.
- Rx  input  1  serial line; idle high; asynchronous to Clock.
- BaudSel  input  3  baud rate: 0=1200, 1=2400, 2=4800, 3=9600, 4=19200, 5=38400, 6=57600, 7=115200.
- ParityEn  input  1  1 = parity bit expected after the data bits.
- ParityOdd  input  1  1 = odd parity, 0 = even; ignored when ParityEn=0.
- RxAck  input  1  one-cycle pulse from the consumer; clears RxReady and Overrun.
- Dataout  output  8  last received byte; held until the next frame is accepted.
- RxReady  output  1  level: unread byte present.
- ParityErr  output  1  parity mismatch on the byte in Dataout.
- FrameErr  output  1  stop bit sampled low on the byte in Dataout.
- Overrun  output  1  sticky: a frame completed while RxReady=1.
- Busy  output  1  FSM not in IDLE.

Behaviour:
- Reset (Rst=0 at a clock edge):
  - All outputs go to 0, FSM to IDLE, divisor and tick counters to 0.
  - Synchroniser flops go to 1.
  - Reset mid-frame abandons the frame with no flag set.
- Input synchronisation: Rx passes through a 2-flop synchroniser; all decisions use the synchronised value rxs.
- Tick generator:
  - Divisor DIV = CLK_HZ / (baud*16), integer-truncated; the 8-entry table is computed at elaboration.
  - Emits a one-cycle tick every DIV clocks.
  - The divisor counter restarts at 0 on IDLE -> START.
- Configuration: BaudSel, ParityEn and ParityOdd are latched on IDLE -> START. Changes mid-frame take effect from the next frame.
- FSM states:
  - IDLE: on a falling edge of rxs (prev=1, now=0), go to START with tick count 0.
  - START: at tick 7, if rxs=1 the start was a glitch, return to IDLE with no flags. If rxs=0, reset tick count to 0 and go to DATA.
  - DATA: sample rxs at tick 7 of each bit into the shift register, LSB first. After bit 7, go to PARITY if ParityEn, else STOP.
  - PARITY: sample at tick 7. Error if (XOR of data ^ sampled bit) != ParityOdd. Go to STOP.
  - STOP: sample at tick 7, then commit. If stop=1 go to IDLE. If stop=0, set FrameErr and go to BREAK.
  - BREAK: wait until rxs=1, then go to IDLE. This prevents a held-low line from retriggering a frame.
- Commit (one cycle, at the STOP sample):
  - If RxReady=0, or RxAck=1 in the same cycle: load Dataout, ParityErr and FrameErr, and set RxReady=1.
  - Else: the new byte and its flags are discarded, Overrun is set, and Dataout is unchanged.
- RxAck:
  - Clears RxReady and Overrun the next cycle.
  - Ack coincident with commit: the new byte loads, RxReady stays 1, Overrun is cleared.
  - Ack while RxReady=0 has no effect.
- Latency: RxReady rises 1 clock after the mid-stop-bit sample, i.e. about 9.5 bit times after the start edge (10.5 with parity), plus 2 clocks of synchroniser delay.
- Busy is 1 in every state except IDLE. It is combinational from the state register.

Test Plan:
- Reset behaviour, 9600 baud, no parity: drive Rst=0 for 3 clocks with Rx toggling → all outputs are 0 and Busy=0. Then send 0xA5 → Dataout=0xA5 and RxReady=1 about 9.5*1920 clocks after the start edge; ParityErr=0, FrameErr=0.
- Parity, BaudSel=7 (DIV=10), ParityEn=1, ParityOdd=0:
  - Send 0x37 with parity bit 1 → ParityErr=0.
  - Resend with parity bit 0 → ParityErr=1, Dataout=0x37.
  - Repeat with ParityOdd=1 → the flags invert.
- Glitch rejection: pulse Rx low for 5*DIV clocks → FSM returns to IDLE, RxReady stays 0, no flags; Busy high only during the glitch window.
- Framing and break, BaudSel=7: send 0x00 with stop=0, then hold Rx low for 30 bit times → one commit with FrameErr=1 and no further frames until Rx returns high. A following 0x5A is then received cleanly.
- Overrun and ack:
  - Send 0x11 and 0x22 without ack → Dataout=0x11, Overrun=1.
  - Pulse RxAck → RxReady=0 and Overrun=0 next cycle.
  - Send 0x33 with RxAck asserted in the commit cycle → Dataout=0x33, RxReady=1, Overrun=0.
- Mid-frame reset and reconfiguration:
  - Assert Rst at data bit 4 → the frame is dropped and Busy=0.
  - Change BaudSel 7→3 during a frame → the current byte is still received at 115200, the next byte at 9600.

Source files
------------

// File: rtl/rx_uart.sv
// rx_uart: 16x-oversampled UART receiver (8 data bits, optional parity, 1 stop) with ready/ack handshake
module rx_uart #(
    parameter int CLK_HZ = 18_432_000,
    parameter int OVS    = 16
) (
    input  logic       Clock,
    input  logic       Rst,
    input  logic       Rx,
    input  logic [2:0] BaudSel,
    input  logic       ParityEn,
    input  logic       ParityOdd,
    input  logic       RxAck,
    output logic [7:0] Dataout,
    output logic       RxReady,
    output logic       ParityErr,
    output logic       FrameErr,
    output logic       Overrun,
    output logic       Busy
);
    localparam int BAUD [8] = '{1200, 2400, 4800, 9600, 19200, 38400, 57600, 115200};
    localparam int DIVW = $clog2(CLK_HZ / (1200 * OVS) + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

    logic [DIVW-1:0] div_tab [8];
    for (genvar i = 0; i < 8; i++) begin : g_div
        assign div_tab[i] = DIVW'(CLK_HZ / (BAUD[i] * OVS));
    end

    state_t          state_q, state_d;
    logic [1:0]      sync_q, sync_d;
    logic            prev_q, prev_d;
    logic [DIVW-1:0] div_q, div_d;
    logic [3:0]      tck_q, tck_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      sh_q, sh_d;
    logic            par_q, par_d;
    logic [2:0]      sel_q, sel_d;
    logic            pen_q, pen_d;
    logic            podd_q, podd_d;
    logic [7:0]      data_q, data_d;
    logic            rdy_q, rdy_d;
    logic            perr_q, perr_d;
    logic            ferr_q, ferr_d;
    logic            ovr_q, ovr_d;
    logic            rxs, tick, samp;

    // The start-bit sample re-zeroes the tick counter, so every later sample lands 16 ticks on, mid-bit
    assign rxs  = sync_q[1];
    assign tick = div_q == div_tab[sel_q] - DIVW'(1);
    assign samp = tick && tck_q == (state_q == START ? 4'd7 : 4'd15);

    // Next-state, tick generation, deserialisation and commit/handshake logic
    always_comb begin
        state_d = state_q;
        sync_d  = {sync_q[0], Rx};
        prev_d  = rxs;
        div_d   = div_q;
        tck_d   = tck_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        par_d   = par_q;
        sel_d   = sel_q;
        pen_d   = pen_q;
        podd_d  = podd_q;
        data_d  = data_q;
        rdy_d   = rdy_q & ~RxAck;
        ovr_d   = ovr_q & ~RxAck;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        if (state_q != IDLE && state_q != BREAK) begin
            div_d = tick ? '0 : div_q + DIVW'(1);
            tck_d = tick ? tck_q + 4'd1 : tck_q;
        end
        case (state_q)
            IDLE: if (prev_q && !rxs) begin
                state_d = START;
                div_d   = '0;
                tck_d   = '0;
                sel_d   = BaudSel;
                pen_d   = ParityEn;
                podd_d  = ParityOdd;
            end
            START: if (samp) begin
                state_d = rxs ? IDLE : DATA;
                tck_d   = '0;
                bit_d   = '0;
            end
            DATA: if (samp) begin
                sh_d  = {rxs, sh_q[7:1]};
                bit_d = bit_q + 3'd1;
                if (bit_q == 3'd7) state_d = pen_q ? PARITY : STOP;
            end
            PARITY: if (samp) begin
                par_d   = rxs;
                state_d = STOP;
            end
            STOP: if (samp) begin
                state_d = rxs ? IDLE : BREAK;
                if (!rdy_q || RxAck) begin
                    data_d = sh_q;
                    perr_d = pen_q && ((^sh_q ^ par_q) != podd_q);
                    ferr_d = !rxs;
                    rdy_d  = 1'b1;
                end else begin
                    ovr_d = 1'b1;
                end
            end
            BREAK: if (rxs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous active-low reset; synchroniser resets to the idle-high line level
    always_ff @(posedge Clock) begin
        if (!Rst) begin
            state_q <= IDLE;
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            div_q   <= '0;
            tck_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            sel_q   <= '0;
            pen_q   <= 1'b0;
            podd_q  <= 1'b0;
            data_q  <= '0;
            rdy_q   <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            div_q   <= div_d;
            tck_q   <= tck_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            sel_q   <= sel_d;
            pen_q   <= pen_d;
            podd_q  <= podd_d;
            data_q  <= data_d;
            rdy_q   <= rdy_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign Dataout   = data_q;
    assign RxReady   = rdy_q;
    assign ParityErr = perr_q;
    assign FrameErr  = ferr_q;
    assign Overrun   = ovr_q;
    assign Busy      = state_q != IDLE;
endmodule

// File: tb/tb_rx_uart.sv
// tb_rx_uart: randomized frame stimulus with a scoreboard of expected commits checked by a monitor
module tb_rx_uart;
    logic       Clock = 1'b0, Rst = 1'b0, Rx = 1'b1, ParityEn = 1'b0, ParityOdd = 1'b0, RxAck = 1'b0;
    logic [2:0] BaudSel = 3'd3;
    logic [7:0] Dataout;
    logic       RxReady, ParityErr, FrameErr, Overrun, Busy;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        int         t0;
        int         lat;
    } exp_t;

    exp_t sb [$];
    exp_t e;
    int   n_chk = 0, n_fail = 0, cyc = 0, lat;
    logic ack_seen = 1'b0, rdy_prev = 1'b0;

    rx_uart dut (
        .Clock(Clock), .Rst(Rst), .Rx(Rx), .BaudSel(BaudSel), .ParityEn(ParityEn),
        .ParityOdd(ParityOdd), .RxAck(RxAck), .Dataout(Dataout), .RxReady(RxReady),
        .ParityErr(ParityErr), .FrameErr(FrameErr), .Overrun(Overrun), .Busy(Busy)
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;
    always @(posedge Clock) ack_seen <= RxAck;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int div_of(input logic [2:0] sel);
        int baud [8] = '{1200, 2400, 4800, 9600, 19200, 38400, 57600, 115200};
        return 18_432_000 / (baud[sel] * 16);
    endfunction

    // A commit is visible as RxReady rising, or RxReady staying high across an ack
    always @(negedge Clock) begin
        if (RxReady && (!rdy_prev || ack_seen)) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL commit: unexpected byte %0h got, none expected", Dataout);
            end else begin
                e = sb.pop_front();
                chk("data", 32'(Dataout), 32'(e.data));
                chk("parity_err", 32'(ParityErr), 32'(e.perr));
                chk("frame_err", 32'(FrameErr), 32'(e.ferr));
                lat = cyc - e.t0;
                n_chk++;
                if (lat < e.lat || lat > e.lat + 4) begin
                    n_fail++;
                    $display("FAIL latency: got %0d expected %0d..%0d", lat, e.lat, e.lat + 4);
                end
            end
        end
        rdy_prev = RxReady;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge Clock);
    endtask

    task automatic ack();
        RxAck = 1'b1;
        @(negedge Clock);
        RxAck = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit pok, input logic stop, input bit push, input bit ackc);
        int   bt = 16 * div_of(BaudSel);
        logic pb;
        exp_t x;
        pb     = (($countones(d) % 2) == 1) ^ ParityOdd ^ !pok;
        x.data = d;
        x.perr = ParityEn && ((($countones(d) + int'(pb)) % 2) != int'(ParityOdd));
        x.ferr = !stop;
        x.t0   = cyc;
        x.lat  = (ParityEn ? 21 : 19) * bt / 2;
        if (push) sb.push_back(x);
        Rx = 1'b0;
        idle(bt);
        for (int i = 0; i < 8; i++) begin
            Rx = d[i];
            idle(bt);
        end
        if (ParityEn) begin
            Rx = pb;
            idle(bt);
        end
        Rx = stop;
        for (int k = 0; k < bt; k++) begin
            RxAck = ackc && k == bt / 2 + 2;
            @(negedge Clock);
        end
        RxAck = 1'b0;
    endtask

    initial begin
        @(negedge Clock);
        for (int i = 0; i < 3; i++) begin
            Rx = ~Rx;
            @(negedge Clock);
        end
        Rx = 1'b1;
        chk("rst_dataout", 32'(Dataout), 0);
        chk("rst_ready", 32'(RxReady), 0);
        chk("rst_perr", 32'(ParityErr), 0);
        chk("rst_ferr", 32'(FrameErr), 0);
        chk("rst_overrun", 32'(Overrun), 0);
        chk("rst_busy", 32'(Busy), 0);
        @(negedge Clock);
        Rst = 1'b1;
        idle(10);

        send_frame(8'hA5, 1, 1, 1, 0);
        ack();
        idle(10);

        BaudSel = 3'd7;
        ParityEn = 1'b1;
        for (int p = 0; p < 2; p++) begin
            ParityOdd = p[0];
            send_frame(8'h37, 1, 1, 1, 0);
            ack();
            idle(5);
            send_frame(8'h37, 0, 1, 1, 0);
            ack();
            idle(5);
        end

        Rx = 1'b0;
        idle(20);
        chk("glitch_busy_high", 32'(Busy), 1);
        idle(30);
        Rx = 1'b1;
        idle(70);
        chk("glitch_busy_low", 32'(Busy), 0);
        chk("glitch_ready", 32'(RxReady), 0);

        ParityEn = 1'b0;
        send_frame(8'h00, 1, 0, 1, 0);
        idle(30 * 160);
        chk("break_busy", 32'(Busy), 1);
        ack();
        idle(320);
        chk("break_no_retrigger", 32'(RxReady), 0);
        Rx = 1'b1;
        idle(20);
        chk("break_exit_busy", 32'(Busy), 0);
        send_frame(8'h5A, 1, 1, 1, 0);
        ack();
        idle(10);

        send_frame(8'h11, 1, 1, 1, 0);
        send_frame(8'h22, 1, 1, 0, 0);
        idle(5);
        chk("ovr_dataout", 32'(Dataout), 32'h11);
        chk("ovr_flag", 32'(Overrun), 1);
        chk("ovr_ready", 32'(RxReady), 1);
        ack();
        chk("ack_ready", 32'(RxReady), 0);
        chk("ack_overrun", 32'(Overrun), 0);
        idle(5);
        send_frame(8'h44, 1, 1, 1, 0);
        send_frame(8'h55, 1, 1, 0, 0);
        idle(5);
        chk("ovr2_flag", 32'(Overrun), 1);
        send_frame(8'h33, 1, 1, 1, 1);
        idle(5);
        chk("coinc_dataout", 32'(Dataout), 32'h33);
        chk("coinc_ready", 32'(RxReady), 1);
        chk("coinc_overrun", 32'(Overrun), 0);
        ack();
        idle(10);

        Rx = 1'b0;
        idle(160);
        for (int i = 0; i < 4; i++) begin
            Rx = i[0];
            idle(160);
        end
        Rx = 1'b0;
        idle(80);
        Rst = 1'b0;
        @(negedge Clock);
        Rst = 1'b1;
        Rx = 1'b1;
        chk("midrst_busy", 32'(Busy), 0);
        idle(400);
        chk("midrst_ready", 32'(RxReady), 0);

        fork
            send_frame(8'hC3, 1, 1, 1, 0);
            begin
                idle(4 * 160);
                BaudSel = 3'd3;
            end
        join
        ack();
        idle(10);
        send_frame(8'h96, 1, 1, 1, 0);
        ack();
        idle(10);

        for (int n = 0; n < 10; n++) begin
            logic stop;
            BaudSel   = ($urandom_range(0, 3) == 0) ? 3'd6 : 3'd7;
            ParityEn  = 1'($urandom_range(0, 1));
            ParityOdd = 1'($urandom_range(0, 1));
            stop      = $urandom_range(0, 7) != 0;
            send_frame(8'($urandom), $urandom_range(0, 3) != 0, stop, 1, 0);
            Rx = 1'b1;
            ack();
            idle($urandom_range(4, 30));
        end

        idle(50);
        chk("scoreboard_empty", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
